// File: rtl/rv32_dmem_responder.sv
// rtl/rv32_dmem_responder.sv - rv32 data-port responder: single-port word array behind a posted store buffer
// Optional feature: define DMEM_BYPASS_EN to forward buffered store data to hitting loads instead of stalling.
module rv32_dmem_responder #(
    parameter int DEPTH    = 1024,
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_enable,
    input  logic        data_read,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_store,
    output logic [31:0] data_fetch,
    output logic        data_valid,
    output logic        mem_stall,
    output logic        addr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SB_DEPTH);

    logic [31:0]   mem     [DEPTH];
    logic [AW-1:0] sb_idx  [SB_DEPTH];
    logic [31:0]   sb_data [SB_DEPTH];
    logic [SW-1:0] head;
    logic [SW-1:0] tail;
    logic [SW:0]   count;

    logic [AW-1:0] widx;
    logic          addr_bad;
    logic          sb_hit;
    logic [31:0]   hit_data;
    logic          is_load;
    logic          accept;
    logic          load_acc;
    logic          array_rd;
    logic          drain;
    logic          push;

    assign widx     = data_addr[AW+1:2];
    // Range is judged on the whole address so high bits never alias into the array.
    assign addr_bad = (|data_addr[1:0]) | (|data_addr[31:AW+2]);
    assign is_load  = data_enable & data_read;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [SW-1:0] p;
        sb_hit   = 1'b0;
        hit_data = '0;
        p        = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            p = head + SW'(i);
            if (((SW+1)'(i) < count) && (sb_idx[p] == widx)) begin
                sb_hit   = 1'b1;
                hit_data = sb_data[p];
            end
        end
    end

`ifdef DMEM_BYPASS_EN
    assign mem_stall = 1'b0;
`else
    assign mem_stall = ~rst & is_load & ~addr_bad & sb_hit;
`endif

    assign accept   = data_enable & ~mem_stall;
    assign load_acc = accept & data_read;
    assign array_rd = load_acc & ~addr_bad & ~sb_hit;
    assign drain    = ~rst & (count != '0) & ~array_rd;
    assign push     = ~rst & accept & ~data_read & ~addr_bad;

    always_ff @(posedge clk) begin
        if (drain) begin
            mem[sb_idx[head]] <= sb_data[head];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_idx[tail]  <= widx;
            sb_data[tail] <= data_store;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (drain) begin
                head <= head + 1'b1;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            count <= count + {{SW{1'b0}}, push} - {{SW{1'b0}}, drain};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_fetch <= '0;
            data_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            data_valid <= load_acc;
            addr_err   <= accept & addr_bad;
            if (load_acc) begin
                if (addr_bad) begin
                    data_fetch <= '0;
                end else if (sb_hit) begin
                    data_fetch <= hit_data;
                end else begin
                    data_fetch <= mem[widx];
                end
            end
        end
    end
endmodule

// File: tb/tb_rv32_dmem_responder.sv
// tb/tb_rv32_dmem_responder.sv - randomized bench for rv32_dmem_responder against a queue-based memory model
module tb_rv32_dmem_responder;
    localparam int DEPTH    = 1024;
    localparam int SB_DEPTH = 4;
`ifdef DMEM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        data_enable;
    logic        data_read;
    logic [31:0] data_addr;
    logic [31:0] data_store;
    logic [31:0] data_fetch;
    logic        data_valid;
    logic        mem_stall;
    logic        addr_err;

    rv32_dmem_responder #(.DEPTH(DEPTH), .SB_DEPTH(SB_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_enable(data_enable),
        .data_read  (data_read),
        .data_addr  (data_addr),
        .data_store (data_store),
        .data_fetch (data_fetch),
        .data_valid (data_valid),
        .mem_stall  (mem_stall),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: what the memory holds once every posted store has landed, plus the pending queue.
    typedef struct {
        int          idx;
        logic [31:0] d;
    } ent_t;

    logic [31:0] mref  [DEPTH];
    bit          known [DEPTH];
    ent_t        q[$];
    logic [31:0] hold;
    bit          hold_known;

    task automatic cyc(input bit r, input bit e, input bit rdi, input logic [31:0] a,
                       input logic [31:0] w, output bit stalled);
        bit          bad, hit, stall, acc, aread, exp_valid, exp_err;
        int          idx;
        logic [31:0] hd;
        rst = r; data_enable = e; data_read = rdi; data_addr = a; data_store = w;
        #4;
        bad = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
        idx = int'((a >> 2) % DEPTH);
        hit = 1'b0;
        hd  = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && q[i].idx == idx) begin
                hit = 1'b1;
                hd  = q[i].d;
            end
        end
        stall = !r && e && rdi && !bad && hit && !BYPASS;
        check("mem_stall", {31'b0, mem_stall}, {31'b0, stall});
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            exp_valid  = 1'b0;
            exp_err    = 1'b0;
            hold       = '0;
            hold_known = 1'b1;
        end else begin
            acc       = e && !stall;
            aread     = acc && rdi && !bad && !hit;
            exp_valid = acc && rdi;
            exp_err   = acc && bad;
            if (acc && rdi) begin
                if (bad) begin
                    hold = '0; hold_known = 1'b1;
                end else if (hit) begin
                    hold = hd; hold_known = 1'b1;
                end else begin
                    hold = mref[idx]; hold_known = known[idx];
                end
            end
            if (!aread && q.size() > 0) begin
                mref[q[0].idx]  = q[0].d;
                known[q[0].idx] = 1'b1;
                void'(q.pop_front());
            end
            if (acc && !rdi && !bad) q.push_back('{idx, w});
            if (q.size() > SB_DEPTH) check("model_depth", q.size(), SB_DEPTH);
        end
        check("data_valid", {31'b0, data_valid}, {31'b0, exp_valid});
        check("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
        if (hold_known) check("data_fetch", data_fetch, hold);
        stalled = stall;
    endtask

    task automatic req(input bit e, input bit rdi, input logic [31:0] a, input logic [31:0] w);
        bit s;
        int n = 0;
        do begin
            cyc(1'b0, e, rdi, a, w, s);
            n++;
        end while (s && n < 3 * SB_DEPTH);
        if (s) check("stall_bound", {31'b0, s}, 32'd0);
    endtask

    task automatic idle(input int n);
        bit s;
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, s);
    endtask

    task automatic do_reset(input int n);
        bit s;
        repeat (n) cyc(1'b1, 1'b1, 1'b1, 32'h40, 32'd0, s);
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        hold_known = 1'b0;
        rst = 1'b1; data_enable = 1'b1; data_read = 1'b1; data_addr = '0; data_store = '0;
        @(posedge clk);
        #1;
        do_reset(2);
        req(1'b1, 1'b1, 32'h100, 32'd0);

        req(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        idle(2);
        req(1'b1, 1'b1, 32'h10, 32'd0);
        check("deadbeef", data_fetch, 32'hDEAD_BEEF);

        for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 32'(i * 4), 32'(i + 1));
        req(1'b1, 1'b1, 32'h4, 32'd0);
        check("word1", data_fetch, 32'h2);

        req(1'b1, 1'b0, 32'h20, 32'hA);
        req(1'b1, 1'b0, 32'h20, 32'hB);
        req(1'b1, 1'b1, 32'h20, 32'd0);
        check("youngest", data_fetch, 32'hB);

        req(1'b1, 1'b1, 32'h3, 32'd0);
        req(1'b1, 1'b0, 32'(DEPTH * 4), 32'h5555_5555);
        req(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h6666_6666);
        idle(2);
        req(1'b1, 1'b1, 32'h0, 32'd0);
        check("word0_kept", data_fetch, 32'h1);

        for (int i = 0; i < 16; i++) req(1'b1, 1'b0, 32'(i * 4), 32'h100 + 32'(i));
        idle(2);
        for (int i = 0; i < 8; i++) req(1'b1, 1'b1, 32'(i * 4), 32'd0);

        req(1'b1, 1'b0, 32'h14, 32'hBAD0_0005);
        do_reset(1);
        req(1'b1, 1'b1, 32'h14, 32'd0);
        check("reset_discard", data_fetch, 32'h105);

        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15)) << 2;
            case (k)
                0, 1, 2, 3: begin
                    req(1'b1, 1'b0, a, $urandom);
                    if ($urandom_range(0, 2) == 0) req(1'b1, 1'b1, a, 32'd0);
                end
                4, 5, 6, 7: req(1'b1, 1'b1, a, 32'd0);
                8:          idle(1);
                default: begin
                    if ($urandom_range(0, 1) == 0) a = a | 32'($urandom_range(1, 3));
                    else a = 32'(DEPTH * 4) + (32'($urandom) & 32'h7FFF_FFFC);
                    req(1'b1, 1'($urandom_range(0, 1)), a, $urandom);
                end
            endcase
        end
        idle(SB_DEPTH + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
